// File: rtl/core_pkg.sv
// Core-wide rename/ROB types shared by the recovery logic.
// Field widths follow the architectural and physical register counts.
package core_pkg;
  localparam int RENAME_WIDTH = 2;
  localparam int NUM_AREGS    = 32;
  localparam int NUM_PREGS    = 64;
  localparam int ROB_DEPTH    = 16;

  typedef logic [$clog2(NUM_AREGS)-1:0] areg_t;
  typedef logic [$clog2(NUM_PREGS)-1:0] preg_t;
  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;

  typedef struct packed {
    logic  has_dst;
    areg_t areg;
    preg_t old_preg;
    preg_t new_preg;
  } rob_undo_t;
endpackage

// File: rtl/undo_collision_filter.sv
// Drops a lane's RAT restore when an older lane restores the same areg,
// so the oldest mapping in the group is the one that lands.
module undo_collision_filter
  import core_pkg::*;
#(
  parameter int W = 2
) (
  input  logic  [W-1:0] act_i,
  input  areg_t [W-1:0] areg_i,
  output logic  [W-1:0] wr_en_o
);

  always_comb begin
    wr_en_o = act_i;
    for (int k = 0; k < W; k++) begin
      for (int j = k + 1; j < W; j++) begin
        if (act_i[j] && (areg_i[j] == areg_i[k])) begin
          wr_en_o[k] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rat_recovery_ctrl.sv
// Mispredict recovery: walks the ROB from tail back to the flushing entry,
// restoring old RAT mappings and freeing the speculative pregs.
module rat_recovery_ctrl
  import core_pkg::*;
#(
  parameter  int WALK_WIDTH = core_pkg::RENAME_WIDTH,
  parameter  int ROB_DEPTH  = core_pkg::ROB_DEPTH,
  localparam int IDXW       = $clog2(ROB_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_valid,
  input  logic      [IDXW-1:0]              flush_rob_idx,
  input  logic      [IDXW-1:0]              rob_tail,
  output logic                              flush_ready,
  output logic      [WALK_WIDTH-1:0][IDXW-1:0] rob_rd_idx,
  input  rob_undo_t [WALK_WIDTH-1:0]        rob_rd_data,
  output logic      [WALK_WIDTH-1:0]        rat_w_en,
  output areg_t     [WALK_WIDTH-1:0]        rat_w_areg,
  output preg_t     [WALK_WIDTH-1:0]        rat_w_preg,
  output logic      [WALK_WIDTH-1:0]        fl_ret_en,
  output preg_t     [WALK_WIDTH-1:0]        fl_ret_preg,
  output logic                              rename_stall,
  output logic                              recovery_done
);

  localparam int CNTW = IDXW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   cursor_q, cursor_d;
  logic [IDXW-1:0]   remaining_q, remaining_d;

  logic [CNTW-1:0]       n_act;
  logic [WALK_WIDTH-1:0] lane_dst;
  logic [WALK_WIDTH-1:0] rat_en;

  always_comb begin
    if ({1'b0, remaining_q} < CNTW'(WALK_WIDTH)) begin
      n_act = {1'b0, remaining_q};
    end else begin
      n_act = CNTW'(WALK_WIDTH);
    end
  end

  always_comb begin
    lane_dst = '0;
    for (int k = 0; k < WALK_WIDTH; k++) begin
      rob_rd_idx[k]  = cursor_q - IDXW'(k);
      lane_dst[k]    = (state_q == WALK) &&
                       (CNTW'(k) < n_act) &&
                       rob_rd_data[k].has_dst;
      rat_w_areg[k]  = rob_rd_data[k].areg;
      rat_w_preg[k]  = rob_rd_data[k].old_preg;
      fl_ret_preg[k] = rob_rd_data[k].new_preg;
    end
  end

  undo_collision_filter #(
    .W(WALK_WIDTH)
  ) u_filter (
    .act_i  (lane_dst),
    .areg_i (rat_w_areg),
    .wr_en_o(rat_en)
  );

  assign rat_w_en  = rst ? '0 : rat_en;
  assign fl_ret_en = rst ? '0 : lane_dst;

  always_comb begin
    state_d       = state_q;
    cursor_d      = cursor_q;
    remaining_d   = remaining_q;
    flush_ready   = 1'b0;
    rename_stall  = 1'b0;
    recovery_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_ready = 1'b1;
        if (flush_valid) begin
          cursor_d    = rob_tail - 1'b1;
          remaining_d = rob_tail - flush_rob_idx - 1'b1;
          state_d     = (remaining_d != '0) ? WALK : DONE;
        end
      end
      WALK: begin
        rename_stall = 1'b1;
        cursor_d     = cursor_q - n_act[IDXW-1:0];
        remaining_d  = remaining_q - n_act[IDXW-1:0];
        if (remaining_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rename_stall  = 1'b1;
        recovery_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      rename_stall  = 1'b0;
      recovery_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Randomized bench for rat_recovery_ctrl against a list-based undo model.
// Tracks restored RAT contents and freed pregs across whole recoveries.
module tb_rat_recovery_ctrl;
  import core_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  flush_valid;
  logic      [3:0]       flush_rob_idx;
  logic      [3:0]       rob_tail;
  logic                  flush_ready;
  logic      [1:0][3:0]  rob_rd_idx;
  rob_undo_t [1:0]       rob_rd_data;
  logic      [1:0]       rat_w_en;
  areg_t     [1:0]       rat_w_areg;
  preg_t     [1:0]       rat_w_preg;
  logic      [1:0]       fl_ret_en;
  preg_t     [1:0]       fl_ret_preg;
  logic                  rename_stall;
  logic                  recovery_done;

  rob_undo_t rob_mem [16];
  preg_t     exp_rat [32];
  preg_t     dut_rat [32];

  int n_chk;
  int n_fail;

  rat_recovery_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush_valid  (flush_valid),
    .flush_rob_idx(flush_rob_idx),
    .rob_tail     (rob_tail),
    .flush_ready  (flush_ready),
    .rob_rd_idx   (rob_rd_idx),
    .rob_rd_data  (rob_rd_data),
    .rat_w_en     (rat_w_en),
    .rat_w_areg   (rat_w_areg),
    .rat_w_preg   (rat_w_preg),
    .fl_ret_en    (fl_ret_en),
    .fl_ret_preg  (fl_ret_preg),
    .rename_stall (rename_stall),
    .recovery_done(recovery_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rob_rd_data[k] = rob_mem[rob_rd_idx[k]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rob();
    for (int i = 0; i < 16; i++) begin
      rob_mem[i] = rob_undo_t'($urandom);
      rob_mem[i].areg = areg_t'($urandom_range(0, 3));
    end
  endtask

  task automatic do_flush(input int tail, input int idx, input bit hold);
    int        n, cyc, base, na;
    int        q[$];
    int        exp_cnt, got_cnt, exp_sum, got_sum, bad;
    bit        wexp;
    rob_undo_t e;
    exp_cnt = 0;
    got_cnt = 0;
    exp_sum = 0;
    got_sum = 0;
    n = (tail - idx - 1) & 15;
    for (int i = 0; i < n; i++) q.push_back((tail - 1 - i) & 15);
    for (int i = 0; i < n; i++) begin
      e = rob_mem[q[i]];
      if (e.has_dst) begin
        exp_rat[e.areg] = e.old_preg;
        exp_cnt++;
        exp_sum += int'(e.new_preg);
      end
    end
    @(negedge clk);
    chk("ready_idle", 32'(flush_ready), 1);
    flush_valid   = 1'b1;
    rob_tail      = tail[3:0];
    flush_rob_idx = idx[3:0];
    @(posedge clk);
    #1;
    if (hold) begin
      rob_tail      = 4'($urandom);
      flush_rob_idx = 4'($urandom);
    end else begin
      flush_valid = 1'b0;
    end
    cyc = (n + 1) / 2;
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      chk("walk_stall", 32'(rename_stall), 1);
      chk("walk_ready", 32'(flush_ready), 0);
      chk("walk_done", 32'(recovery_done), 0);
      base = 2 * c;
      na = (n - base < 2) ? n - base : 2;
      for (int k = 0; k < 2; k++) begin
        if (k < na) begin
          e = rob_mem[q[base+k]];
          chk("rd_idx", 32'(rob_rd_idx[k]), q[base+k]);
          chk("fl_en", 32'(fl_ret_en[k]), 32'(e.has_dst));
          if (e.has_dst) chk("fl_preg", 32'(fl_ret_preg[k]), 32'(e.new_preg));
          wexp = e.has_dst;
          for (int j = k + 1; j < na; j++) begin
            if (rob_mem[q[base+j]].has_dst &&
                rob_mem[q[base+j]].areg == e.areg) wexp = 1'b0;
          end
          chk("rat_en", 32'(rat_w_en[k]), 32'(wexp));
          if (wexp) begin
            chk("rat_areg", 32'(rat_w_areg[k]), 32'(e.areg));
            chk("rat_preg", 32'(rat_w_preg[k]), 32'(e.old_preg));
          end
        end else begin
          chk("fl_en_off", 32'(fl_ret_en[k]), 0);
          chk("rat_en_off", 32'(rat_w_en[k]), 0);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (rat_w_en[k]) dut_rat[rat_w_areg[k]] = rat_w_preg[k];
        if (fl_ret_en[k]) begin
          got_cnt++;
          got_sum += int'(fl_ret_preg[k]);
        end
      end
    end
    @(negedge clk);
    chk("done_pulse", 32'(recovery_done), 1);
    chk("done_stall", 32'(rename_stall), 1);
    chk("done_ready", 32'(flush_ready), 0);
    chk("done_en", 32'({rat_w_en, fl_ret_en}), 0);
    flush_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(flush_ready), 1);
    chk("idle_done", 32'(recovery_done), 0);
    chk("idle_stall", 32'(rename_stall), 0);
    chk("idle_en", 32'({rat_w_en, fl_ret_en}), 0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut_rat[i] !== exp_rat[i]) bad++;
    chk("rat_state", bad, 0);
    chk("free_cnt", got_cnt, exp_cnt);
    chk("free_sum", got_sum, exp_sum);
  endtask

  task automatic rst_walk();
    @(negedge clk);
    chk("r_ready0", 32'(flush_ready), 1);
    flush_valid   = 1'b1;
    rob_tail      = 4'd7;
    flush_rob_idx = 4'd0;
    @(posedge clk);
    #1;
    rob_tail      = 4'd3;
    flush_rob_idx = 4'd9;
    @(negedge clk);
    chk("r_walk_stall", 32'(rename_stall), 1);
    chk("r_walk_ready", 32'(flush_ready), 0);
    chk("r_walk_idx0", 32'(rob_rd_idx[0]), 6);
    chk("r_walk_idx1", 32'(rob_rd_idx[1]), 5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("r_rst_en", 32'({rat_w_en, fl_ret_en}), 0);
    chk("r_rst_stall", 32'(rename_stall), 0);
    chk("r_rst_done", 32'(recovery_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush_valid = 1'b0;
    @(negedge clk);
    chk("r_after_ready", 32'(flush_ready), 1);
    chk("r_after_stall", 32'(rename_stall), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r_quiet_en", 32'({rat_w_en, fl_ret_en}), 0);
      chk("r_quiet_done", 32'(recovery_done), 0);
      chk("r_quiet_ready", 32'(flush_ready), 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    flush_valid   = 1'b0;
    rob_tail      = '0;
    flush_rob_idx = '0;
    fill_rob();
    for (int i = 0; i < 32; i++) begin
      exp_rat[i] = preg_t'(i);
      dut_rat[i] = preg_t'(i);
    end
    flush_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_en", 32'({rat_w_en, fl_ret_en}), 0);
      chk("rst_stall", 32'(rename_stall), 0);
      chk("rst_done", 32'(recovery_done), 0);
    end
    flush_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(flush_ready), 1);
    chk("reset_stall", 32'(rename_stall), 0);

    rob_mem[2].has_dst = 1'b0;
    do_flush(5, 1, 1'b0);
    do_flush(1, 14, 1'b0);
    do_flush(8, 7, 1'b1);
    rob_mem[6] = '{has_dst: 1'b1, areg: 5'd5, old_preg: 6'd40, new_preg: 6'd50};
    rob_mem[5] = '{has_dst: 1'b1, areg: 5'd5, old_preg: 6'd33, new_preg: 6'd45};
    do_flush(7, 4, 1'b0);
    chk("coll_rat5", 32'(dut_rat[5]), 33);
    rst_walk();
    do_flush(3, 3, 1'b0);

    for (int it = 0; it < 40; it++) begin
      fill_rob();
      do_flush($urandom_range(0, 15), $urandom_range(0, 15),
               1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
